// File: rtl/mem_stage.sv
// Memory-access stage: latches EX outputs, runs LW/LB/SW/SB on a
// ready-handshaked data RAM, drives write-back and forwarding.
module mem_stage #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_mem_data,
  input  logic              ex_load_byte,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_write_reg,
  output logic              mem_busy,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready,
  output logic              wb_reg_write,
  output logic [4:0]        wb_write_reg,
  output logic [31:0]       wb_data,
  output logic              fwd_reg_write,
  output logic [4:0]        fwd_reg,
  output logic [31:0]       fwd_data,
  output logic              mem_err
);

  localparam logic IDLE   = 1'b0;
  localparam logic ACCESS = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic              state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              byte_q, byte_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              regw_q, regw_d;
  logic [4:0]        dst_q, dst_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wbw_q, wbw_d;
  logic [4:0]        wbr_q, wbr_d;
  logic [31:0]       wbd_q, wbd_d;
  logic              err_q, err_d;

  logic [7:0]        lane;
  logic [31:0]       ld_val;
  logic [3:0]        be;
  logic [31:0]       wdata;

  // Byte lane select, enables and write data for the latched access
  always_comb begin
    lane = ram_rdata[7:0];
    be   = 4'b0001;
    unique case (addr_q[1:0])
      2'd0: begin lane = ram_rdata[7:0];   be = 4'b0001; end
      2'd1: begin lane = ram_rdata[15:8];  be = 4'b0010; end
      2'd2: begin lane = ram_rdata[23:16]; be = 4'b0100; end
      2'd3: begin lane = ram_rdata[31:24]; be = 4'b1000; end
      default: ;
    endcase
    if (byte_q) begin
      ld_val = {{24{lane[7]}}, lane};
      wdata  = {4{mdata_q[7:0]}};
    end else begin
      ld_val = ram_rdata;
      wdata  = mdata_q;
      be     = 4'b1111;
    end
  end

  // Next-state: capture in IDLE, wait for ready or timeout in ACCESS
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mdata_d = mdata_q;
    byte_d  = byte_q;
    read_d  = read_q;
    write_d = write_q;
    regw_d  = regw_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wbw_d   = 1'b0;
    wbr_d   = wbr_q;
    wbd_d   = wbd_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d  = ex_result[ADDR_W+1:0];
        mdata_d = ex_mem_data;
        byte_d  = ex_load_byte;
        read_d  = ex_mem_read;
        write_d = ex_mem_write;
        regw_d  = ex_reg_write;
        dst_d   = ex_write_reg;
        cnt_d   = 8'd0;
        if (ex_mem_read || ex_mem_write) begin
          state_d = ACCESS;
        end else begin
          wbw_d = ex_reg_write;
          wbr_d = ex_write_reg;
          wbd_d = ex_result;
        end
      end
      ACCESS: begin
        if (ram_ready) begin
          state_d = IDLE;
          wbw_d   = read_q & ~write_q & regw_q;
          wbr_d   = dst_q;
          wbd_d   = ld_val;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mdata_q <= '0;
      byte_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      regw_q  <= 1'b0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wbw_q   <= 1'b0;
      wbr_q   <= '0;
      wbd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mdata_q <= mdata_d;
      byte_q  <= byte_d;
      read_q  <= read_d;
      write_q <= write_d;
      regw_q  <= regw_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wbw_q   <= wbw_d;
      wbr_q   <= wbr_d;
      wbd_q   <= wbd_d;
      err_q   <= err_d;
    end
  end

  assign mem_busy  = state_q;
  assign ram_req   = state_q;
  assign ram_we    = state_q & write_q;
  assign ram_addr  = state_q ? addr_q[ADDR_W+1:2] : '0;
  assign ram_be    = state_q ? be : 4'b0000;
  assign ram_wdata = state_q ? wdata : 32'd0;

  assign wb_reg_write  = wbw_q;
  assign wb_write_reg  = wbr_q;
  assign wb_data       = wbd_q;
  assign fwd_reg_write = wbw_q;
  assign fwd_reg       = wbr_q;
  assign fwd_data      = wbd_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through table, memory-op
// table, timeout, and reset-during-access sequences.
module tb_mem_stage;

  localparam int ADDR_W  = 20;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       ex_result;
  logic [31:0]       ex_mem_data;
  logic              ex_load_byte;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic [4:0]        ex_write_reg;
  logic              mem_busy;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;
  logic              wb_reg_write;
  logic [4:0]        wb_write_reg;
  logic [31:0]       wb_data;
  logic              fwd_reg_write;
  logic [4:0]        fwd_reg;
  logic [31:0]       fwd_data;
  logic              mem_err;

  int tests = 0;
  int fails = 0;

  mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_result(ex_result), .ex_mem_data(ex_mem_data),
    .ex_load_byte(ex_load_byte), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_busy(mem_busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .fwd_reg_write(fwd_reg_write),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        rw;
    logic [4:0]  dst;
    logic        wbw;
    logic [31:0] wbd;
  } avec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] md;
    logic        lb;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [4:0]  dst;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wbw;
    logic [31:0] wbd;
  } mvec_t;

  avec_t av[4];
  mvec_t mv[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop(input logic rw);
    ex_result    = 32'h5A5A_5A5A;
    ex_mem_data  = 32'h0;
    ex_load_byte = 1'b1;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_reg_write = rw;
    ex_write_reg = 5'd31;
  endtask

  task automatic run_mem(input mvec_t v);
    ex_result    = v.res;
    ex_mem_data  = v.md;
    ex_load_byte = v.lb;
    ex_mem_read  = v.rd;
    ex_mem_write = v.wr;
    ex_reg_write = v.rw;
    ex_write_reg = v.dst;
    tick();
    drive_nop(1'b1);
    ram_rdata = v.rdata;
    for (int k = 0; k <= v.waits; k++) begin
      chk("acc_busy", {31'd0, mem_busy}, 32'd1);
      chk("acc_req", {31'd0, ram_req}, 32'd1);
      chk("acc_we", {31'd0, ram_we}, {31'd0, v.we});
      chk("acc_addr", {12'd0, ram_addr}, v.addr);
      chk("acc_be", {28'd0, ram_be}, {28'd0, v.be});
      chk("acc_wdata", ram_wdata, v.wdata);
      chk("acc_wbw", {31'd0, wb_reg_write}, 32'd0);
      ram_ready = (k == v.waits);
      tick();
    end
    ram_ready = 1'b0;
    chk("done_busy", {31'd0, mem_busy}, 32'd0);
    chk("done_req", {31'd0, ram_req}, 32'd0);
    chk("done_err", {31'd0, mem_err}, 32'd0);
    chk("done_wbw", {31'd0, wb_reg_write}, {31'd0, v.wbw});
    chk("done_fwdw", {31'd0, fwd_reg_write}, {31'd0, v.wbw});
    if (v.wbw) begin
      chk("done_wbd", wb_data, v.wbd);
      chk("done_wbr", {27'd0, wb_write_reg}, {27'd0, v.dst});
      chk("done_fwdd", fwd_data, v.wbd);
      chk("done_fwdr", {27'd0, fwd_reg}, {27'd0, v.dst});
    end
    tick();
    chk("next_wbw", {31'd0, wb_reg_write}, 32'd1);
    chk("next_wbd", wb_data, 32'h5A5A_5A5A);
    chk("next_wbr", {27'd0, wb_write_reg}, 32'd31);
    chk("next_busy", {31'd0, mem_busy}, 32'd0);
  endtask

  initial begin
    int n;
    av[0] = '{32'h0000_1234, 1'b1, 5'd5,  1'b1, 32'h0000_1234};
    av[1] = '{32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 32'hFFFF_FFFF};
    av[2] = '{32'h8000_0001, 1'b0, 5'd12, 1'b0, 32'h8000_0001};
    av[3] = '{32'h0000_0000, 1'b1, 5'd31, 1'b1, 32'h0000_0000};

    mv[0] = '{32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,
              3, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h4, 32'h0,
              1'b1, 32'hDEAD_BEEF};
    mv[1] = '{32'h0000_0013, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,
              1, 32'h80FF_0000, 4'b1000, 1'b0, 32'h4, 32'h0,
              1'b1, 32'hFFFF_FF80};
    mv[2] = '{32'h0000_0012, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,
              0, 32'h80FF_0000, 4'b0100, 1'b0, 32'h4, 32'h0,
              1'b1, 32'hFFFF_FFFF};
    mv[3] = '{32'h0000_0021, 32'h0000_00AB, 1'b1, 1'b0, 1'b1, 1'b1,
              5'd10, 0, 32'h0, 4'b0010, 1'b1, 32'h8, 32'hABAB_ABAB,
              1'b0, 32'h0};
    mv[4] = '{32'h0000_0100, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0,
              5'd0, 2, 32'h0, 4'b1111, 1'b1, 32'h40, 32'h1234_5678,
              1'b0, 32'h0};
    mv[5] = '{32'h0000_0001, 32'h1122_3344, 1'b1, 1'b1, 1'b0, 1'b1,
              5'd11, 0, 32'h0000_7F00, 4'b0010, 1'b0, 32'h0,
              32'h4444_4444, 1'b1, 32'h0000_007F};
    mv[6] = '{32'h0000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1,
              5'd12, 1, 32'h1111_1111, 4'b1111, 1'b1, 32'h2,
              32'hCAFE_F00D, 1'b0, 32'h0};
    mv[7] = '{32'h0000_0FFC, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13,
              TIMEOUT - 1, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h3FF,
              32'h0, 1'b1, 32'h0BAD_F00D};
    mv[8] = '{32'h0000_0007, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd14,
              0, 32'h89AB_CDEF, 4'b1111, 1'b0, 32'h1, 32'h0,
              1'b1, 32'h89AB_CDEF};
    mv[9] = '{32'hFFF0_0042, 32'h0000_00FF, 1'b1, 1'b1, 1'b0, 1'b1,
              5'd15, 0, 32'h0055_0000, 4'b0100, 1'b0, 32'hC0010,
              32'hFFFF_FFFF, 1'b1, 32'h0000_0055};

    rst = 1'b1;
    ex_result = '0; ex_mem_data = '0; ex_load_byte = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_reg_write = 1'b0; ex_write_reg = '0;
    ram_rdata = '0; ram_ready = 1'b0;
    repeat (2) tick();
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_req", {31'd0, ram_req}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", {12'd0, ram_addr}, 32'd0);
    chk("rst_be", {28'd0, ram_be}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_wb", {26'd0, wb_reg_write, wb_write_reg}, 32'd0);
    chk("rst_wbd", wb_data, 32'd0);
    chk("rst_fwd", {26'd0, fwd_reg_write, fwd_reg}, 32'd0);
    chk("rst_fwdd", fwd_data, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (av[i]) begin
      ex_result    = av[i].res;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
      ex_reg_write = av[i].rw;
      ex_write_reg = av[i].dst;
      tick();
      chk("alu_wbw", {31'd0, wb_reg_write}, {31'd0, av[i].wbw});
      chk("alu_wbr", {27'd0, wb_write_reg}, {27'd0, av[i].dst});
      chk("alu_wbd", wb_data, av[i].wbd);
      chk("alu_fwdw", {31'd0, fwd_reg_write}, {31'd0, av[i].wbw});
      chk("alu_fwdr", {27'd0, fwd_reg}, {27'd0, av[i].dst});
      chk("alu_fwdd", fwd_data, av[i].wbd);
      chk("alu_busy", {31'd0, mem_busy}, 32'd0);
    end

    foreach (mv[i]) run_mem(mv[i]);

    ex_result = 32'h0000_0040; ex_mem_data = 32'h0;
    ex_load_byte = 1'b0; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_reg_write = 1'b1; ex_write_reg = 5'd3;
    ram_ready = 1'b0;
    tick();
    drive_nop(1'b0);
    n = 0;
    while (mem_busy === 1'b1 && n < 40) begin
      chk("to_err_low", {31'd0, mem_err}, 32'd0);
      n++;
      tick();
    end
    chk("to_cycles", n, TIMEOUT);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_req", {31'd0, ram_req}, 32'd0);
    chk("to_wbw", {31'd0, wb_reg_write}, 32'd0);
    chk("to_busy", {31'd0, mem_busy}, 32'd0);
    tick();
    chk("to_err_pulse", {31'd0, mem_err}, 32'd0);

    ex_result = 32'h0000_0080; ex_mem_read = 1'b1;
    ex_load_byte = 1'b0; ex_reg_write = 1'b1; ex_write_reg = 5'd4;
    tick();
    drive_nop(1'b0);
    chk("ra_req_pre", {31'd0, ram_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ra_req", {31'd0, ram_req}, 32'd0);
    chk("ra_busy", {31'd0, mem_busy}, 32'd0);
    chk("ra_wbw", {31'd0, wb_reg_write}, 32'd0);
    chk("ra_be", {28'd0, ram_be}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ram_ready = 1'b1;
    ram_rdata = 32'h7777_7777;
    tick();
    ram_ready = 1'b0;
    chk("ra_idle", {31'd0, mem_busy}, 32'd0);
    chk("ra_nocomp", {31'd0, wb_reg_write}, 32'd0);
    chk("ra_noerr", {31'd0, mem_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
